trail_fb_reader: RTL and testbench
==================================

// Module: trail_fb_reader
// PURPOSE
//  Read side of the trail framebuffer RAM (640x480, one 8-bit code per pixel) written by the player blocks.
//  Turns scan coordinates from the VGA timing block into RAM read addresses and maps returned codes to RGB pixels.
//  Overlays the arena border on those pixels.
//  Serves collision probes from the player FSMs in RAM slots left free by the scan (blanking), with a req/ack handshake.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line; RAM row stride
//  V_ACTIVE  480  visible lines
//  ADDR_W    19   RAM address width
//  DATA_W    8    RAM word / trail code width
//  RD_LAT    2    RAM read latency in VGA_CLK cycles (registered addr + registered q)
//  BORDER    16   border thickness in pixels
// PORTS
//  VGA_CLK     in   1       pixel clock; the only clock
//  reset       in   1       asynchronous, active-high reset
//  next_x      in   10      x of next pixel to draw
//  next_y      in   10      y of next pixel to draw
//  active_in   in   1       next_x/next_y lie in the visible area
//  rd_addr     out  ADDR_W  RAM read address
//  rd_data     in   DATA_W  RAM q, valid RD_LAT cycles after rd_addr
//  probe_req   in   1       collision probe request (level, held until ack)
//  probe_x     in   10      probe x
//  probe_y     in   10      probe y
//  probe_ack   out  1       one-cycle pulse: probe result valid
//  probe_hit   out  1       cell occupied (code!=0) or out of range
//  probe_code  out  DATA_W  code read; 8'hFF when out of range
//  pix_r/g/b   out  8 each  pixel colour to VGA block
//  pix_valid   out  1       pix_* belongs to a visible pixel
// BEHAVIOUR
//  Reset: rd_addr=0, probe_ack=0, probe_hit=0, probe_code=0, pix_*=0, pix_valid=0, FSM=IDLE, tag pipe cleared.
//  Reset mid-probe: probe dropped, no ack; requester must re-request.
//  Address: addr = x + y*H_ACTIVE, computed as (y<<9)+(y<<7)+x; max 307199, fits 19 bits.
//  rd_addr is registered. Slot arbitration at each edge: active_in=1 -> scan slot. Else probe in SLOT state -> probe slot.
//  Otherwise rd_addr holds its value.
//  Scan has absolute priority. A probe waits at most one horizontal active period (640 cycles).
//  Scan latency: pixel for coords sampled at edge N appears on pix_* after edge N+RD_LAT+1.
//  Tag pipe (RD_LAT+1 stages) carries {active, border, is_probe} alongside each read.
//  Colour map (active): code 0 -> (0,0,0); 8'h01 -> (255,255,0); 8'h80 -> (0,255,255); other non-zero -> (255,255,255).
//  Border (x<BORDER | x>=H_ACTIVE-BORDER | y<BORDER | y>=V_ACTIVE-BORDER) overrides the code: (255,0,0).
//  Inactive slot: pix_*=0, pix_valid=0.
//  Probe FSM:
//   IDLE: probe_req=1 -> latch probe_x/y.
//    Out of range (x>=H_ACTIVE | y>=V_ACTIVE) -> ACK with hit=1, code=8'hFF; no RAM read.
//    In range -> SLOT.
//   SLOT: first edge with active_in=0 issues the probe address -> WAIT; counter loaded with RD_LAT.
//   WAIT: count down; at 0 capture rd_data into probe_code, hit=(rd_data!=0) -> ACK.
//   ACK: probe_ack=1 for exactly one cycle -> IDLE.
//  probe_hit/probe_code hold until the next ack.
//  Requests:
//   probe_req dropped before ack: the probe still completes and acks.
//   New request accepted no earlier than the cycle after ack.
//   Coordinates are latched, so later probe_x/y changes are ignored.
//  A scan slot and a probe result never share a tag stage; the scan output is unaffected by probe traffic.
// STRUCTURE
//  trail_pkg: H_ACTIVE, V_ACTIVE, BORDER, trail codes (CODE_EMPTY=0, CODE_P1=8'h01, CODE_P2=8'h80, CODE_OOR=8'hFF),
//   colour constants, probe FSM state encodings.
//  Sub-module trail_tag_pipe: parameterised RD_LAT+1 deep shift register with async reset, carrying the slot tags.
//  Address calc, arbiter, FSM and colour map stay in trail_fb_reader.
// TESTING (bench models RAM with RD_LAT=2)
//  1 Reset mid-frame: all outputs 0; after release, (0,0) active -> pix_valid=1 at edge+3.
//  2 RAM[32100]=8'h01, scan (100,50):
//    rd_addr=32100; pix=(255,255,0) after RD_LAT+1=3 edges.
//    (101,50) with RAM=0 -> (0,0,0).
//  3 Scan (5,200) with RAM[128005]=8'h01 -> (255,0,0).
//    Scan (623,463) -> (0,0,0) when RAM=0.
//    Scan (624,463) -> (255,0,0).
//  4 RAM[153816]=8'h01; probe_req at (216,240) while active_in=1:
//    no probe address while active.
//    After active_in falls: rd_addr=153816, ack 3 cycles later with hit=1, code=8'h01.
//  5 probe (640,10):
//    ack on the 2nd edge after req; hit=1, code=8'hFF; rd_addr unchanged.
//  6 Reset asserted in WAIT: no ack ever.
//    Req dropped in SLOT: ack still issued.
//    Back-to-back reqs both acked, separate pulses.

Source files
------------

// File: rtl/trail_pkg.sv
// Shared constants, trail codes, colours and types for the trail framebuffer read side.
package trail_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] BORDER   = 10'd16;
  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;
  localparam int RD_LAT = 2;

  localparam logic [DATA_W-1:0] CODE_EMPTY = 8'h00;
  localparam logic [DATA_W-1:0] CODE_P1    = 8'h01;
  localparam logic [DATA_W-1:0] CODE_P2    = 8'h80;
  localparam logic [DATA_W-1:0] CODE_OOR   = 8'hFF;

  localparam logic [23:0] RGB_BLACK  = 24'h000000;
  localparam logic [23:0] RGB_YELLOW = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN   = 24'h00FFFF;
  localparam logic [23:0] RGB_WHITE  = 24'hFFFFFF;
  localparam logic [23:0] RGB_RED    = 24'hFF0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SLOT,
    ST_WAIT,
    ST_ACK
  } probe_state_t;

  typedef struct packed {
    logic active;
    logic border;
    logic is_probe;
  } slot_tag_t;

  // x + y*640 using shifts only: y*512 + y*128 + x
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [9:0] x, input logic [9:0] y);
    logic [ADDR_W-1:0] yw;
    yw = ADDR_W'(y);
    return (yw << 9) + (yw << 7) + ADDR_W'(x);
  endfunction

  function automatic logic [23:0] code_to_rgb(input logic [DATA_W-1:0] code);
    logic [23:0] rgb;
    case (code)
      CODE_EMPTY: rgb = RGB_BLACK;
      CODE_P1:    rgb = RGB_YELLOW;
      CODE_P2:    rgb = RGB_CYAN;
      default:    rgb = RGB_WHITE;
    endcase
    return rgb;
  endfunction

endpackage

// File: rtl/trail_tag_pipe.sv
// Shift register carrying slot tags alongside RAM reads so they line up with rd_data.
module trail_tag_pipe #(
  parameter int DEPTH = 3,
  parameter int W     = 3
) (
  input  logic         VGA_CLK,
  input  logic         reset,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out
);

  logic [DEPTH-1:0][W-1:0] stage_reg;

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_reg[i] <= stage_reg[i-1];
      end
    end
  end

  assign tag_out = stage_reg[DEPTH-1];

endmodule

// File: rtl/trail_fb_reader.sv
// Framebuffer read side: scan address generation, colour map with border overlay,
// and collision probes served in the blanking slots the scan leaves free.
module trail_fb_reader
  import trail_pkg::*;
(
  input  logic              VGA_CLK,
  input  logic              reset,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  input  logic              active_in,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              probe_req,
  input  logic [9:0]        probe_x,
  input  logic [9:0]        probe_y,
  output logic              probe_ack,
  output logic              probe_hit,
  output logic [DATA_W-1:0] probe_code,
  output logic [7:0]        pix_r,
  output logic [7:0]        pix_g,
  output logic [7:0]        pix_b,
  output logic              pix_valid
);

  localparam int CNT_W = $clog2(RD_LAT + 1);

  probe_state_t     state_reg;
  logic [9:0]       px_reg, py_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             oor_reg;
  logic             scan_border;
  logic             probe_slot;
  slot_tag_t        tag_in, tag_out;

  assign scan_border = (next_x < BORDER) || (next_x >= H_ACTIVE - BORDER) ||
                       (next_y < BORDER) || (next_y >= V_ACTIVE - BORDER);
  assign probe_slot  = (state_reg == ST_SLOT) && !active_in;

  assign tag_in.active   = active_in;
  assign tag_in.border   = active_in && scan_border;
  assign tag_in.is_probe = probe_slot;

  // Scan always wins the read port; a probe only gets a slot during blanking.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      rd_addr <= '0;
    end else if (active_in) begin
      rd_addr <= calc_addr(next_x, next_y);
    end else if (probe_slot) begin
      rd_addr <= calc_addr(px_reg, py_reg);
    end
  end

  trail_tag_pipe #(
    .DEPTH(RD_LAT + 1),
    .W    ($bits(slot_tag_t))
  ) u_tag_pipe (
    .VGA_CLK(VGA_CLK),
    .reset  (reset),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      pix_valid <= 1'b0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
    end else if (tag_out.active && !tag_out.is_probe) begin
      pix_valid <= 1'b1;
      {pix_r, pix_g, pix_b} <= tag_out.border ? RGB_RED : code_to_rgb(rd_data);
    end else begin
      pix_valid <= 1'b0;
      pix_r     <= '0;
      pix_g     <= '0;
      pix_b     <= '0;
    end
  end

  // Out-of-range probes pass through WAIT with a zero count so their ack
  // takes the same registered path as RAM-backed probes, without a read.
  always_ff @(posedge VGA_CLK or posedge reset) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      px_reg     <= '0;
      py_reg     <= '0;
      cnt_reg    <= '0;
      oor_reg    <= 1'b0;
      probe_ack  <= 1'b0;
      probe_hit  <= 1'b0;
      probe_code <= '0;
    end else begin
      probe_ack <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (probe_req) begin
            px_reg <= probe_x;
            py_reg <= probe_y;
            if ((probe_x >= H_ACTIVE) || (probe_y >= V_ACTIVE)) begin
              oor_reg   <= 1'b1;
              cnt_reg   <= '0;
              state_reg <= ST_WAIT;
            end else begin
              oor_reg   <= 1'b0;
              state_reg <= ST_SLOT;
            end
          end
        end
        ST_SLOT: begin
          if (!active_in) begin
            cnt_reg   <= CNT_W'(RD_LAT);
            state_reg <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_reg == '0) begin
            probe_ack <= 1'b1;
            if (oor_reg) begin
              probe_hit  <= 1'b1;
              probe_code <= CODE_OOR;
            end else begin
              probe_hit  <= (rd_data != CODE_EMPTY);
              probe_code <= rd_data;
            end
            state_reg <= ST_ACK;
          end else begin
            cnt_reg <= cnt_reg - 1'b1;
          end
        end
        ST_ACK:  state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trail_fb_reader.sv
// Scoreboard bench for trail_fb_reader with a 2-cycle RAM model.
module tb_trail_fb_reader;
  import trail_pkg::*;

  logic        VGA_CLK = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  next_x = '0, next_y = '0;
  logic        active_in = 1'b0;
  logic [18:0] rd_addr;
  logic [7:0]  rd_data;
  logic        probe_req = 1'b0;
  logic [9:0]  probe_x = '0, probe_y = '0;
  logic        probe_ack, probe_hit;
  logic [7:0]  probe_code, pix_r, pix_g, pix_b;
  logic        pix_valid;

  trail_fb_reader dut (
    .VGA_CLK(VGA_CLK), .reset(reset),
    .next_x(next_x), .next_y(next_y), .active_in(active_in),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .probe_req(probe_req), .probe_x(probe_x), .probe_y(probe_y),
    .probe_ack(probe_ack), .probe_hit(probe_hit), .probe_code(probe_code),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_valid(pix_valid)
  );

  always #5 VGA_CLK = ~VGA_CLK;

  int cyc = 0;
  always @(posedge VGA_CLK) cyc++;

  // RAM model: registered address, registered q
  logic [7:0]  mem [int];
  logic [18:0] ram_addr;
  function automatic logic [7:0] mem_rd(input int a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction
  always @(posedge VGA_CLK) begin
    ram_addr <= rd_addr;
    rd_data  <= mem_rd(int'(ram_addr));
  end

  typedef struct {
    int          due;
    logic [24:0] px;
  } pix_exp_t;
  pix_exp_t   pix_q[$];
  logic [8:0] prb_q[$];

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ack_cnt = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [24:0] exp_pix(input int x, input int y);
    logic [7:0] c;
    if (x < 16 || x >= 624 || y < 16 || y >= 464) return {1'b1, 24'hFF0000};
    c = mem_rd(x + y * 640);
    if (c == 8'h00) return {1'b1, 24'h000000};
    if (c == 8'h01) return {1'b1, 24'hFFFF00};
    if (c == 8'h80) return {1'b1, 24'h00FFFF};
    return {1'b1, 24'hFFFFFF};
  endfunction

  always @(negedge VGA_CLK) begin
    if (!reset && mon_en) begin
      if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
        pix_exp_t e;
        e = pix_q.pop_front();
        check("pix", 32'({pix_valid, pix_r, pix_g, pix_b}), 32'(e.px));
        $display("pixel cycle %0d rgb=%02h%02h%02h valid=%0b", cyc, pix_r, pix_g, pix_b, pix_valid);
      end else begin
        check("pix_idle", 32'({pix_valid, pix_r, pix_g, pix_b}), 32'h0);
      end
      if (probe_ack) begin
        ack_cnt++;
        if (prb_q.size() == 0) begin
          check("probe_unexpected_ack", 32'h1, 32'h0);
        end else begin
          logic [8:0] pe;
          pe = prb_q.pop_front();
          check("probe_result", 32'({probe_hit, probe_code}), 32'(pe));
          $display("probe ack cycle %0d hit=%0b code=%02h", cyc, probe_hit, probe_code);
        end
      end
    end
  end

  task automatic tick();
    @(posedge VGA_CLK);
    #1;
  endtask

  task automatic scan(input int x, input int y);
    pix_exp_t e;
    next_x = 10'(x);
    next_y = 10'(y);
    active_in = 1'b1;
    e.due = cyc + 4;
    e.px  = exp_pix(x, y);
    pix_q.push_back(e);
    tick();
    check("scan_rd_addr", 32'(rd_addr), 32'(x + y * 640));
  endtask

  task automatic wait_ack(output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (probe_ack) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) check("ack_timeout", 32'h0, 32'h1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_addr"}, 32'(rd_addr), 32'h0);
    check({tag, "_ack"}, 32'({probe_ack, probe_hit, probe_code}), 32'h0);
    check({tag, "_pix"}, 32'({pix_valid, pix_r, pix_g, pix_b}), 32'h0);
  endtask

  int lat, snap, rd_before;

  initial begin
    mem[32100]  = 8'h01;
    mem[128005] = 8'h01;
    mem[153816] = 8'h01;
    mem[38450]  = 8'h80;
    mem[64102]  = 8'h80;
    mem[64103]  = 8'h42;

    // 1: reset, mid-frame reset, first pixel after release
    repeat (3) tick();
    check_reset_outputs("por");
    reset = 1'b0;
    mon_en = 1'b1;
    tick();
    scan(300, 100);
    scan(301, 100);
    reset = 1'b1;
    active_in = 1'b0;
    pix_q.delete();
    prb_q.delete();
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    reset = 1'b0;
    scan(0, 0);
    active_in = 1'b0;
    repeat (4) tick();

    // 2, 3: colour map and border
    scan(100, 50);
    scan(101, 50);
    scan(5, 200);
    scan(623, 463);
    scan(624, 463);
    scan(102, 100);
    scan(103, 100);
    active_in = 1'b0;
    repeat (4) tick();

    // 4: probe held off by scan, issued when active_in falls
    scan(400, 240);
    probe_req = 1'b1;
    probe_x = 10'd216;
    probe_y = 10'd240;
    prb_q.push_back(9'h101);
    scan(401, 240);
    scan(402, 240);
    scan(403, 240);
    active_in = 1'b0;
    probe_x = 10'd0;
    tick();
    check("probe_rd_addr", 32'(rd_addr), 32'd153816);
    wait_ack(lat);
    check("probe_latency", 32'(lat), 32'd3);
    probe_req = 1'b0;
    repeat (3) tick();

    // 5: out-of-range probe, no RAM read
    rd_before = int'(rd_addr);
    probe_req = 1'b1;
    probe_x = 10'd640;
    probe_y = 10'd10;
    prb_q.push_back(9'h1FF);
    wait_ack(lat);
    check("oor_latency", 32'(lat), 32'd2);
    check("oor_rd_addr", 32'(rd_addr), 32'(rd_before));
    probe_req = 1'b0;
    repeat (3) tick();

    // 6a: reset while waiting for RAM data drops the probe
    probe_req = 1'b1;
    probe_x = 10'd50;
    probe_y = 10'd60;
    tick();
    tick();
    check("wait_rd_addr", 32'(rd_addr), 32'd38450);
    tick();
    reset = 1'b1;
    probe_req = 1'b0;
    pix_q.delete();
    prb_q.delete();
    #1;
    check("rst_wait_ack", 32'(probe_ack), 32'h0);
    tick();
    tick();
    reset = 1'b0;
    snap = ack_cnt;
    repeat (10) tick();
    check("no_ack_after_rst", 32'(ack_cnt - snap), 32'h0);

    // 6b: request dropped in SLOT still completes
    scan(100, 100);
    probe_req = 1'b1;
    probe_x = 10'd50;
    probe_y = 10'd60;
    prb_q.push_back(9'h180);
    scan(101, 100);
    probe_req = 1'b0;
    scan(102, 100);
    scan(103, 100);
    active_in = 1'b0;
    wait_ack(lat);
    check("dropped_req_latency", 32'(lat), 32'd4);
    repeat (3) tick();

    // 6c: back-to-back requests give two separate pulses
    snap = ack_cnt;
    probe_req = 1'b1;
    probe_x = 10'd20;
    probe_y = 10'd30;
    prb_q.push_back(9'h000);
    wait_ack(lat);
    check("b2b_first_latency", 32'(lat), 32'd5);
    probe_x = 10'd100;
    probe_y = 10'd480;
    prb_q.push_back(9'h1FF);
    wait_ack(lat);
    check("b2b_second_latency", 32'(lat), 32'd3);
    probe_req = 1'b0;
    repeat (4) tick();
    check("b2b_ack_count", 32'(ack_cnt - snap), 32'd2);
    check("result_hold", 32'({probe_ack, probe_hit, probe_code}), 32'h1FF);

    repeat (6) tick();
    check("pix_queue_drained", 32'(pix_q.size()), 32'h0);
    check("probe_queue_drained", 32'(prb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
